// File: rtl/node_sim_pkg.sv
// Shared types and default constants for the switch-level node simulator.
package node_sim_pkg;

  localparam int W_DEFAULT = 16;
  localparam int HI        = 2 ** (W_DEFAULT - 2);
  localparam int LO        = -(2 ** (W_DEFAULT - 2));

  typedef enum logic [1:0] {
    T_NMOS   = 2'd0,
    T_VCC    = 2'd1,
    T_VSS    = 2'd2,
    T_PULLUP = 2'd3
  } tr_type_e;

  typedef enum logic [3:0] {
    IDLE,
    T_FETCH,
    T_RG,
    T_RS,
    T_RD,
    T_EVAL,
    A_RD,
    A_WR,
    DONE
  } sweep_state_e;

endpackage

// File: rtl/node_current_eval.sv
// Combinational current evaluation for one transistor-table entry.
module node_current_eval
  import node_sim_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [1:0] ttype,
  input  logic [W-1:0] g,
  input  logic [W-1:0] vs,
  input  logic [W-1:0] vd,
  output logic [W:0]   i_src,
  output logic         src_valid,
  output logic [W:0]   i_drn,
  output logic         drn_valid
);

  localparam logic [W-1:0] HI_V = {2'b01, {(W-2){1'b0}}};
  localparam logic [W-1:0] LO_V = {2'b11, {(W-2){1'b0}}};

  tr_type_e          kind;
  logic              gate_on;
  logic [W-1:0]      s_v;
  logic [W-1:0]      d_v;
  logic signed [W:0] vsd;
  logic signed [W:0] i_t;
  logic signed [W:0] i_cur;
  logic signed [W:0] dv;
  logic signed [W:0] i_p;

  assign kind = tr_type_e'(ttype);

  always_comb begin
    s_v       = vs;
    d_v       = vd;
    src_valid = 1'b0;
    drn_valid = 1'b0;
    i_src     = '0;
    i_drn     = '0;
    gate_on   = ~g[W-1];

    case (kind)
      T_NMOS: begin
        src_valid = 1'b1;
        drn_valid = 1'b1;
      end
      T_VCC: begin
        d_v       = HI_V;
        src_valid = 1'b1;
      end
      T_VSS: begin
        s_v       = LO_V;
        drn_valid = 1'b1;
      end
      default: src_valid = 1'b1;
    endcase

    // Arithmetic shifts of the W+1-bit differences give the sign-extended
    // halving (transistor) and divide-by-16 (pullup) currents.
    vsd   = {d_v[W-1], d_v} - {s_v[W-1], s_v};
    i_t   = vsd >>> 1;
    i_cur = gate_on ? i_t : '0;
    dv    = {HI_V[W-1], HI_V} - {vs[W-1], vs};
    i_p   = dv >>> 4;

    if (kind == T_PULLUP) begin
      i_src = i_p;
    end else begin
      i_src = i_cur;
      i_drn = -i_cur;
    end
  end

endmodule

// File: rtl/node_sweep_sequencer.sv
// Two-phase sweep scheduler: accumulates transistor currents per node, then
// integrates every node voltage once with saturation.
module node_sweep_sequencer
  import node_sim_pkg::*;
#(
  parameter  int W     = W_DEFAULT,
  parameter  int NODES = 64,
  parameter  int TRANS = 256,
  parameter  int SHIFT = 2,
  localparam int NW    = $clog2(NODES),
  localparam int TW    = $clog2(TRANS),
  localparam int DW    = 2 + 3 * NW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] tr_addr,
  input  logic [DW-1:0] tr_data,
  output logic [NW-1:0] nv_raddr,
  input  logic [W-1:0]  nv_rdata,
  output logic [NW-1:0] nv_waddr,
  output logic [W-1:0]  nv_wdata,
  output logic          nv_we
);

  localparam int AW = W + 4;
  localparam logic signed [AW:0] MAX_S = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW:0] MIN_S = {{(AW-W+2){1'b1}}, {(W-1){1'b0}}};

  sweep_state_e state;
  sweep_state_e state_nx;

  logic [TW-1:0] t_cnt;
  logic [NW-1:0] n_cnt;
  logic [1:0]    ty_q;
  logic [NW-1:0] s_q;
  logic [NW-1:0] d_q;
  logic [W-1:0]  vg_q;
  logic [W-1:0]  vs_q;
  logic [AW-1:0] acc [NODES];

  logic [W:0] i_src;
  logic [W:0] i_drn;
  logic       src_valid;
  logic       drn_valid;

  logic signed [AW-1:0] acc_cur;
  logic signed [AW-1:0] acc_sh;
  logic signed [AW:0]   sum;
  logic [W-1:0]         v_new;
  logic                 t_last;
  logic                 n_last;

  assign t_last = (t_cnt == TW'(TRANS - 1));
  assign n_last = (n_cnt == NW'(NODES - 1));

  node_current_eval #(.W(W)) u_eval (
    .ttype     (ty_q),
    .g         (vg_q),
    .vs        (vs_q),
    .vd        (nv_rdata),
    .i_src     (i_src),
    .src_valid (src_valid),
    .i_drn     (i_drn),
    .drn_valid (drn_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = T_FETCH;
      T_FETCH: state_nx = T_RG;
      T_RG:    state_nx = T_RS;
      T_RS:    state_nx = T_RD;
      T_RD:    state_nx = T_EVAL;
      T_EVAL:  state_nx = t_last ? A_RD : T_FETCH;
      A_RD:    state_nx = A_WR;
      A_WR:    state_nx = n_last ? DONE : A_RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    acc_cur = acc[n_cnt];
    acc_sh  = acc_cur >>> SHIFT;
    sum     = {{(AW+1-W){nv_rdata[W-1]}}, nv_rdata} + {acc_sh[AW-1], acc_sh};
    if (sum > MAX_S)      v_new = {1'b0, {(W-1){1'b1}}};
    else if (sum < MIN_S) v_new = {1'b1, {(W-1){1'b0}}};
    else                  v_new = sum[W-1:0];

    busy     = (state != IDLE) && (state != DONE);
    done     = (state == DONE);
    nv_we    = (state == A_WR);
    nv_waddr = nv_we ? n_cnt : '0;
    nv_wdata = nv_we ? v_new : '0;
  end

  // Memory reads are one state ahead: the address registered at the end of a
  // state returns data during the next, where it is captured at its end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_cnt    <= '0;
      n_cnt    <= '0;
      tr_addr  <= '0;
      nv_raddr <= '0;
      ty_q     <= '0;
      s_q      <= '0;
      d_q      <= '0;
      vg_q     <= '0;
      vs_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          t_cnt <= '0;
          n_cnt <= '0;
        end
        T_FETCH: tr_addr <= t_cnt;
        T_RG: begin
          ty_q     <= tr_data[DW-1 -: 2];
          s_q      <= tr_data[2*NW-1 -: NW];
          d_q      <= tr_data[NW-1:0];
          nv_raddr <= tr_data[3*NW-1 -: NW];
        end
        T_RS: begin
          vg_q     <= nv_rdata;
          nv_raddr <= s_q;
        end
        T_RD: begin
          vs_q     <= nv_rdata;
          nv_raddr <= d_q;
        end
        T_EVAL: t_cnt <= t_cnt + 1'b1;
        A_RD:   nv_raddr <= n_cnt;
        A_WR:   n_cnt <= n_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NODES; i++) acc[i] <= '0;
    end else if (state == T_EVAL) begin
      if (!(src_valid && drn_valid && (s_q == d_q))) begin
        if (src_valid) acc[s_q] <= acc[s_q] + {{(AW-W-1){i_src[W]}}, i_src};
        if (drn_valid) acc[d_q] <= acc[d_q] + {{(AW-W-1){i_drn[W]}}, i_drn};
      end
    end else if (state == A_WR) begin
      acc[n_cnt] <= '0;
    end
  end

endmodule

// File: tb/tb_node_sweep_sequencer.sv
// Randomised self-checking bench for node_sweep_sequencer against a sweep-level model.
module tb_node_sweep_sequencer;

  localparam int W     = 16;
  localparam int NODES = 16;
  localparam int TRANS = 32;
  localparam int NW    = 4;
  localparam int TW    = 5;
  localparam int DW    = 14;
  localparam int HI_I  = 16384;
  localparam int LO_I  = -16384;
  localparam int NOM   = 5 * TRANS + 2 * NODES + 1;
  localparam int LIMIT = NOM + 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start0;
  logic busy, done, nv_we, busy0, done0, nv_we0;
  logic [TW-1:0] tr_addr, tr_addr0;
  logic [DW-1:0] tr_data, tr_data0;
  logic [NW-1:0] nv_raddr, nv_waddr, nv_raddr0, nv_waddr0;
  logic [W-1:0]  nv_rdata, nv_wdata, nv_rdata0, nv_wdata0;

  logic [DW-1:0]       rom  [TRANS];
  logic [DW-1:0]       rom0 [TRANS];
  logic signed [W-1:0] ram  [NODES];
  logic signed [W-1:0] ram0 [NODES];

  logic          ld_we, ld_sel;
  logic [NW-1:0] ld_addr;
  logic [W-1:0]  ld_data;

  int done_cnt = 0;
  int errors = 0;
  int checks = 0;

  int            mv   [NODES];
  logic [DW-1:0] mrom [TRANS];

  node_sweep_sequencer #(.W(W), .NODES(NODES), .TRANS(TRANS), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .tr_addr(tr_addr), .tr_data(tr_data), .nv_raddr(nv_raddr), .nv_rdata(nv_rdata),
    .nv_waddr(nv_waddr), .nv_wdata(nv_wdata), .nv_we(nv_we)
  );

  node_sweep_sequencer #(.W(W), .NODES(NODES), .TRANS(TRANS), .SHIFT(0)) dut_s0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .tr_addr(tr_addr0), .tr_data(tr_data0), .nv_raddr(nv_raddr0), .nv_rdata(nv_rdata0),
    .nv_waddr(nv_waddr0), .nv_wdata(nv_wdata0), .nv_we(nv_we0)
  );

  assign tr_data   = rom[tr_addr];
  assign nv_rdata  = ram[nv_raddr];
  assign tr_data0  = rom0[tr_addr0];
  assign nv_rdata0 = ram0[nv_raddr0];

  always @(posedge clk) begin
    if (nv_we) ram[nv_waddr] <= nv_wdata;
    else if (ld_we && !ld_sel) ram[ld_addr] <= ld_data;
    if (nv_we0) ram0[nv_waddr0] <= nv_wdata0;
    else if (ld_we && ld_sel) ram0[ld_addr] <= ld_data;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [DW-1:0] mk(input int ty, input int g, input int s, input int d);
    return {ty[1:0], g[3:0], s[3:0], d[3:0]};
  endfunction

  // Gate-off filler table: node 15 held at -1 drives every gate.
  function automatic void idle_config();
    for (int n = 0; n < NODES; n++) mv[n] = 0;
    mv[15] = -1;
    for (int t = 0; t < TRANS; t++) mrom[t] = mk(0, 15, 14, 13);
  endfunction

  function automatic void random_config();
    for (int n = 0; n < NODES; n++) mv[n] = int'($urandom_range(16383)) - 8192;
    for (int t = 0; t < TRANS; t++)
      mrom[t] = mk(int'($urandom_range(3)), int'($urandom_range(15)),
                   int'($urandom_range(15)), int'($urandom_range(15)));
  endfunction

  // One whole sweep computed from the switch-level rules with integers.
  function automatic void model_sweep(input int shift);
    int acc [NODES];
    int ty, g, s, d, vs, vd, i, nv;
    logic [DW-1:0] e;
    for (int n = 0; n < NODES; n++) acc[n] = 0;
    for (int t = 0; t < TRANS; t++) begin
      e  = mrom[t];
      ty = int'(e[13:12]);
      g  = int'(e[11:8]);
      s  = int'(e[7:4]);
      d  = int'(e[3:0]);
      vs = (ty == 2) ? LO_I : mv[s];
      vd = (ty == 1) ? HI_I : mv[d];
      if (ty == 3) begin
        acc[s] += (HI_I - mv[s]) >>> 4;
      end else begin
        i = (mv[g] >= 0) ? ((vd - vs) >>> 1) : 0;
        if (ty != 2) acc[s] += i;
        if (ty != 1) acc[d] -= i;
      end
    end
    for (int n = 0; n < NODES; n++) begin
      nv = mv[n] + (acc[n] >>> shift);
      if (nv > 32767) nv = 32767;
      if (nv < -32768) nv = -32768;
      mv[n] = nv;
    end
  endfunction

  task automatic load(input bit sel);
    if (sel) rom0 = mrom;
    else     rom  = mrom;
    ld_sel = sel;
    for (int n = 0; n < NODES; n++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = NW'(n);
      ld_data = W'(mv[n]);
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Returns cycles from the accepting edge to the cycle done is seen, or -1.
  task automatic run_sweep(input bit sel, output int cyc);
    @(negedge clk);
    if (sel) start0 = 1'b1;
    else     start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start0 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? done0 : done) && cyc < LIMIT);
    if (!(sel ? done0 : done)) cyc = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (nv_we !== 1'b0) begin errors++; $display("FAIL reset nv_we: got %b expected 0", nv_we); end
    checks++; if (tr_addr !== '0) begin errors++; $display("FAIL reset tr_addr: got %0d expected 0", tr_addr); end
    checks++; if (nv_raddr !== '0) begin errors++; $display("FAIL reset nv_raddr: got %0d expected 0", nv_raddr); end
    checks++; if (nv_waddr !== '0) begin errors++; $display("FAIL reset nv_waddr: got %0d expected 0", nv_waddr); end
    checks++; if (nv_wdata !== '0) begin errors++; $display("FAIL reset nv_wdata: got %0d expected 0", nv_wdata); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_pullup();
    int cyc;
    idle_config();
    mv[7] = -5;
    mrom[0] = mk(3, 7, 1, 9);
    load(0);
    model_sweep(2);
    run_sweep(0, cyc);
    checks++; if (cyc !== NOM) begin errors++; $display("FAIL pullup latency: got %0d expected %0d", cyc, NOM); end
    checks++; if (ram[1] !== 16'sd256) begin errors++; $display("FAIL pullup v1: got %0d expected 256", ram[1]); end
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL pullup node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
  endtask

  task automatic test_nmos_on();
    int cyc;
    idle_config();
    mv[4] = 100; mv[2] = -16384; mv[3] = 16384;
    mrom[0] = mk(0, 4, 2, 3);
    load(0);
    model_sweep(2);
    run_sweep(0, cyc);
    checks++; if (ram[2] !== -16'sd12288) begin errors++; $display("FAIL nmos_on src: got %0d expected -12288", ram[2]); end
    checks++; if (ram[3] !== 16'sd12288)  begin errors++; $display("FAIL nmos_on drn: got %0d expected 12288", ram[3]); end
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL nmos_on node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
  endtask

  task automatic test_nmos_off();
    int cyc;
    idle_config();
    mv[4] = -1; mv[2] = -16384; mv[3] = 16384;
    mrom[0] = mk(0, 4, 2, 3);
    load(0);
    run_sweep(0, cyc);
    checks++; if (ram[2] !== -16'sd16384) begin errors++; $display("FAIL nmos_off src: got %0d expected -16384", ram[2]); end
    checks++; if (ram[3] !== 16'sd16384)  begin errors++; $display("FAIL nmos_off drn: got %0d expected 16384", ram[3]); end
    // A gate-off-only sweep over random voltages exposes any leftover accumulator.
    idle_config();
    for (int n = 0; n < 13; n++) mv[n] = int'($urandom_range(65535)) - 32768;
    load(0);
    run_sweep(0, cyc);
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL acc_clear node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    idle_config();
    mv[4] = 100; mv[5] = 20000; mv[6] = 32767; mv[7] = 32767; mv[8] = 32767;
    mrom[0] = mk(0, 4, 5, 6);
    mrom[1] = mk(0, 4, 5, 7);
    mrom[2] = mk(0, 4, 5, 8);
    load(1);
    model_sweep(0);
    run_sweep(1, cyc);
    checks++; if (cyc !== NOM) begin errors++; $display("FAIL sat latency: got %0d expected %0d", cyc, NOM); end
    checks++; if (ram0[5] !== 16'sd32767) begin errors++; $display("FAIL sat src: got %0d expected 32767", ram0[5]); end
    checks++; if (ram0[6] !== 16'sd26384) begin errors++; $display("FAIL sat drn: got %0d expected 26384", ram0[6]); end
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram0[n] !== W'(mv[n])) begin errors++; $display("FAIL sat node %0d: got %0d expected %0d", n, ram0[n], mv[n]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    random_config();
    load(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5 * 10 + 2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid busy: got %b expected 1", busy); end
    checks++; if (tr_addr !== TW'(10)) begin errors++; $display("FAIL mid tr_addr: got %0d expected 10", tr_addr); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid-reset busy: got %b expected 0", busy); end
    checks++; if (nv_we !== 1'b0) begin errors++; $display("FAIL mid-reset nv_we: got %b expected 0", nv_we); end
    checks++; if (tr_addr !== '0) begin errors++; $display("FAIL mid-reset tr_addr: got %0d expected 0", tr_addr); end
    checks++; if (nv_raddr !== '0) begin errors++; $display("FAIL mid-reset nv_raddr: got %0d expected 0", nv_raddr); end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL mid-reset write node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
    model_sweep(2);
    run_sweep(0, cyc);
    checks++; if (cyc !== NOM) begin errors++; $display("FAIL post-reset latency: got %0d expected %0d", cyc, NOM); end
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL post-reset node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int d0;
    random_config();
    load(0);
    model_sweep(2);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy: got %b expected 1", busy); end
      end
      start = (cyc == 3 || cyc == 4 || cyc == 90);
    end while (!done && cyc < LIMIT);
    start = 1'b0;
    checks++; if (cyc !== NOM) begin errors++; $display("FAIL b2b latency: got %0d expected %0d", cyc, NOM); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b done width: got %b expected 0", done); end
    repeat (NOM + 10) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b done count: got %0d expected 1", done_cnt - d0); end
    for (int n = 0; n < NODES; n++) begin
      checks++;
      if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL b2b node %0d: got %0d expected %0d", n, ram[n], mv[n]); end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int k = 0; k < 4; k++) begin
      random_config();
      load(0);
      model_sweep(2);
      run_sweep(0, cyc);
      checks++; if (cyc !== NOM) begin errors++; $display("FAIL random %0d latency: got %0d expected %0d", k, cyc, NOM); end
      for (int n = 0; n < NODES; n++) begin
        checks++;
        if (ram[n] !== W'(mv[n])) begin errors++; $display("FAIL random %0d node %0d: got %0d expected %0d", k, n, ram[n], mv[n]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pullup();
    test_nmos_on();
    test_nmos_off();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
